// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and types for the async FIFO read-side logic
package fifo_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int RD_LAT = 1;
  localparam int OBUF_DEPTH = 2;
  typedef logic [1:0] occ_t;
endpackage

// File: rtl/stream_obuf.sv
// stream_obuf: 2-entry register FIFO holding words captured from the async FIFO
module stream_obuf
  import fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output occ_t             occ_o
);
  logic [WIDTH-1:0] mem_q [OBUF_DEPTH];
  logic hd_q, hd_d, wr, rd, wa;
  occ_t occ_q, occ_d;
  // With occ = 2 a push is only legal alongside a pop, so the tail slot reuses the departing head.
  always_comb begin
    wr = push_i & ~flush_i;
    rd = pop_i & ~flush_i & (occ_q != '0);
    wa = hd_q ^ occ_q[0];
    occ_d = flush_i ? '0 : occ_t'(occ_q + {1'b0, wr} - {1'b0, rd});
    hd_d = hd_q ^ rd;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      hd_q <= 1'b0;
      occ_q <= '0;
    end else begin
      if (wr) mem_q[wa] <= data_i;
      hd_q <= hd_d;
      occ_q <= occ_d;
    end
  end
  assign data_o = mem_q[hd_q];
  assign occ_o = occ_q;
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains the async FIFO into a valid/ready stream through a 2-word buffer
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic             flush_i,
  input  logic             fifo_empty_i,
  output logic             fifo_r_en_o,
  input  logic [WIDTH-1:0] fifo_rdata_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o,
  output logic [CNT_W-1:0] pop_cnt_o
);
  logic inflight_q, inflight_d, deq;
  logic [CNT_W-1:0] pop_cnt_q, pop_cnt_d;
  logic [2:0] credit;
  occ_t occ;
  // Credit counts buffered plus in-flight words net of this cycle's pop, so slots are never overcommitted.
  always_comb begin
    deq = m_valid_o & m_ready_i;
    credit = 3'(occ) + 3'(inflight_q) - 3'(deq);
    fifo_r_en_o = rst_n & enable_i & ~flush_i & ~fifo_empty_i & (credit < 3'(OBUF_DEPTH));
    inflight_d = fifo_r_en_o;
    pop_cnt_d = pop_cnt_q + CNT_W'(deq & ~flush_i);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      pop_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      pop_cnt_q <= pop_cnt_d;
    end
  end
  stream_obuf #(.WIDTH(WIDTH)) u_obuf (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (inflight_q),
    .pop_i  (m_ready_i),
    .flush_i(flush_i),
    .data_i (fifo_rdata_i),
    .data_o (m_data_o),
    .occ_o  (occ)
  );
  assign m_valid_o = occ != '0;
  assign pop_cnt_o = pop_cnt_q;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: scoreboard bench for fifo_rd_stream with a behavioural FIFO model
module tb_fifo_rd_stream;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1, flush = 1'b0, m_ready = 1'b0;
  logic fifo_empty, fifo_r_en, fifo_r_en_s, m_valid, m_valid_s;
  logic [7:0] fifo_rdata = '0, m_data, m_data_s;
  logic [15:0] pop_cnt;
  logic [3:0] pop_cnt_s;
  logic [7:0] fmem [256];
  int wr_ptr = 0, rd_ptr = 0, n_cmp = 0, n_bad = 0, cnt = 0, p0;
  logic [7:0] exp_q [$];
  logic hold = 1'b0, ok;
  logic [7:0] hold_d, e;

  fifo_rd_stream #(.WIDTH(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .flush_i(flush), .fifo_empty_i(fifo_empty),
    .fifo_r_en_o(fifo_r_en), .fifo_rdata_i(fifo_rdata), .m_valid_o(m_valid), .m_ready_i(m_ready),
    .m_data_o(m_data), .pop_cnt_o(pop_cnt)
  );
  fifo_rd_stream #(.WIDTH(8), .CNT_W(4)) u_small (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .flush_i(flush), .fifo_empty_i(fifo_empty),
    .fifo_r_en_o(fifo_r_en_s), .fifo_rdata_i(fifo_rdata), .m_valid_o(m_valid_s), .m_ready_i(m_ready),
    .m_data_o(m_data_s), .pop_cnt_o(pop_cnt_s)
  );

  always #5 clk = ~clk;
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk)
    if (fifo_r_en) begin
      fifo_rdata <= fmem[rd_ptr[7:0]];
      rd_ptr <= rd_ptr + 1;
    end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [7:0] v, input bit expect_out);
    fmem[wr_ptr[7:0]] = v;
    wr_ptr++;
    if (expect_out) exp_q.push_back(v);
  endtask
  task automatic drain;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick;
    chk("drain_left", exp_q.size(), 0);
  endtask

  always @(negedge clk)
    if (rst_n) begin
      if (hold) begin
        n_cmp++;
        if (!m_valid || m_data !== hold_d) begin
          n_bad++;
          $display("FAIL hold: got v=%0b d=%0h expected v=1 d=%0h", m_valid, m_data, hold_d);
        end
      end
      hold = m_valid & ~m_ready & ~flush;
      hold_d = m_data;
      if (m_valid && m_ready && !flush) begin
        cnt++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_word: got %0h expected none", m_data);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e || m_data_s !== e) begin
            n_bad++;
            $display("FAIL word: got %0h/%0h expected %0h", m_data, m_data_s, e);
          end
        end
      end
    end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    for (int i = 1; i <= 16; i++) load(8'(i), 1'b1);
    repeat (3) tick;
    chk("rst_ren", fifo_r_en, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_cnt", pop_cnt, 0);
    chk("rst_data", m_data, 0);
    rst_n = 1'b1;
    m_ready = 1'b1;
    #1;
    chk("lat_ren_t", fifo_r_en, 1);
    tick;
    chk("lat_valid_t1", m_valid, 0);
    tick;
    chk("lat_valid_t2", m_valid, 1);
    chk("lat_data_t2", m_data, 8'h01);
    chk("occ_t2", u_dut.u_obuf.occ_o, 1);
    tick;
    chk("occ_wr_deq", u_dut.u_obuf.occ_o, 1);
    ok = m_valid;
    repeat (14) begin
      tick;
      ok &= m_valid;
    end
    chk("stream_gap", ok, 1);
    tick;
    chk("stream_end_valid", m_valid, 0);
    chk("stream_cnt", pop_cnt, 16);
    chk("wrap_cnt16", pop_cnt_s, 0);
    chk("stream_left", exp_q.size(), 0);

    m_ready = 1'b0;
    p0 = rd_ptr;
    for (int i = 0; i < 6; i++) load(8'hA0 + 8'(i), 1'b1);
    repeat (5) tick;
    chk("bp_reads", rd_ptr - p0, 2);
    chk("bp_ren", fifo_r_en, 0);
    chk("bp_valid", m_valid, 1);
    chk("bp_data", m_data, 8'hA0);
    m_ready = 1'b1;
    ok = 1'b1;
    repeat (6) begin
      ok &= m_valid;
      tick;
    end
    chk("bp_gap", ok, 1);
    chk("bp_end_valid", m_valid, 0);
    chk("bp_cnt", pop_cnt, 22);
    chk("wrap_cnt22", pop_cnt_s, 6);

    m_ready = 1'b0;
    p0 = rd_ptr;
    for (int i = 0; i < 4; i++) load(8'hC0 + 8'(i), 1'b1);
    repeat (4) tick;
    enable = 1'b0;
    m_ready = 1'b1;
    repeat (5) tick;
    chk("en_off_reads", rd_ptr - p0, 2);
    chk("en_off_ren", fifo_r_en, 0);
    chk("en_off_valid", m_valid, 0);
    chk("en_off_left", exp_q.size(), 2);
    enable = 1'b1;
    drain;
    tick;

    m_ready = 1'b0;
    load(8'hB0, 1'b1);
    load(8'hB1, 1'b0);
    load(8'hB2, 1'b0);
    load(8'hB3, 1'b1);
    load(8'hB4, 1'b1);
    repeat (4) tick;
    m_ready = 1'b1;
    tick;
    flush = 1'b1;
    #1;
    chk("flush_ren", fifo_r_en, 0);
    chk("flush_pre_valid", m_valid, 1);
    tick;
    flush = 1'b0;
    #1;
    chk("flush_valid", m_valid, 0);
    chk("flush_cnt", pop_cnt, 27);
    chk("post_flush_ren", fifo_r_en, 1);
    drain;
    repeat (2) tick;
    chk("final_cnt", pop_cnt, 29);
    chk("wrap_final", pop_cnt_s, 13);
    chk("final_model_cnt", cnt, 29);
    chk("fifo_drained", rd_ptr, wr_ptr);
    chk("small_idle", {fifo_r_en_s, m_valid_s}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
